// File: rtl/store_buffer_if.sv
// Bundles the three traffic groups of the store buffer: commit-side enqueue,
// dcache write port and the load-forwarding search port.
interface store_buffer_if;
  // Commit -> store buffer
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [3:0]  enq_wmask;
  logic [31:0] enq_wdata;
  logic        enq_ready;
  // Store buffer -> dcache
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  // Load search
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        ld_conflict;

  // Environment side: commit stage, dcache and load unit together.
  modport master (
    output enq_valid, enq_addr, enq_wmask, enq_wdata, dmem_resp, ld_addr, ld_rmask,
    input  enq_ready, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
    input  ld_fwd_hit, ld_fwd_data, ld_conflict
  );

  // Store buffer side.
  modport slave (
    input  enq_valid, enq_addr, enq_wmask, enq_wdata, dmem_resp, ld_addr, ld_rmask,
    output enq_ready, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
    output ld_fwd_hit, ld_fwd_data, ld_conflict
  );
endinterface

// File: rtl/store_buffer.sv
// Post-commit store buffer: circular FIFO of word-aligned stores with
// tail coalescing, in-order drain to the dcache and combinational load forwarding.
module store_buffer #(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  store_buffer_if.slave             bus,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(SB_DEPTH):0] count
);

  localparam int unsigned IW = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        sent_to_cache;
  } sb_info_t;

  typedef enum logic {StIdle, StReq} state_e;

  sb_info_t          entry_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q;
  logic [IW-1:0]     head_q, tail_q, youngest;
  logic [IW:0]       count_q;
  state_e            state_q, state_d;

  logic accept, coalesce, push, pop, enter_req;
  logic [31:0] enq_lanes;

  // Byte-lane mask expanded to a 32-bit bit mask.
  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign full          = (count_q == (IW+1)'(SB_DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign bus.enq_ready = !full;

  assign youngest  = tail_q - IW'(1);
  assign enq_lanes = lanes(bus.enq_wmask);
  assign accept    = bus.enq_valid && !full;
  // Only an entry not yet handed to the dcache may absorb a newer store.
  assign coalesce  = accept && valid_q[youngest] && !entry_q[youngest].sent_to_cache &&
                     (entry_q[youngest].addr[31:2] == bus.enq_addr[31:2]);
  assign push      = accept && !coalesce;
  assign pop       = (state_q == StReq) && bus.dmem_resp;
  assign enter_req = (state_q == StIdle) && (state_d == StReq);

  // Entry array, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) entry_q[i] <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (coalesce) begin
        entry_q[youngest].mask <= entry_q[youngest].mask | bus.enq_wmask;
        entry_q[youngest].data <= (entry_q[youngest].data & ~enq_lanes) |
                                  (bus.enq_wdata & enq_lanes);
      end
      if (push) begin
        entry_q[tail_q] <= '{addr: {bus.enq_addr[31:2], 2'b00}, mask: bus.enq_wmask,
                             data: bus.enq_wdata, sent_to_cache: 1'b0};
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IW'(1);
      end
      // Head is never the free tail slot here: entering REQ needs count != 0, push needs !full.
      if (enter_req) entry_q[head_q].sent_to_cache <= 1'b1;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IW'(1);
      end
      if (push && !pop)      count_q <= count_q + (IW+1)'(1);
      else if (pop && !push) count_q <= count_q - (IW+1)'(1);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Drain FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StReq;
      StReq:   if (bus.dmem_resp) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Drain FSM outputs: the head entry is presented only while in REQ.
  always_comb begin
    bus.dmem_write = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wmask = '0;
    bus.dmem_wdata = '0;
    if (state_q == StReq) begin
      bus.dmem_write = 1'b1;
      bus.dmem_addr  = entry_q[head_q].addr;
      bus.dmem_wmask = entry_q[head_q].mask;
      bus.dmem_wdata = entry_q[head_q].data;
    end
  end

  logic          found;
  logic [IW-1:0] sel, scan_idx;

  // Load search: walk back from the youngest slot; invalid slots are skipped,
  // so the first overlapping valid entry is the youngest candidate.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      scan_idx = tail_q - IW'(i + 1);
      if (!found && valid_q[scan_idx] &&
          (entry_q[scan_idx].addr[31:2] == bus.ld_addr[31:2]) &&
          ((entry_q[scan_idx].mask & bus.ld_rmask) != 4'b0000)) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
    bus.ld_fwd_hit  = found && ((entry_q[sel].mask & bus.ld_rmask) == bus.ld_rmask);
    bus.ld_conflict = found && !bus.ld_fwd_hit;
    bus.ld_fwd_data = found ? entry_q[sel].data : 32'h0;
  end

endmodule
